keypad_code_buffer: RTL and testbench

Parametrised keypad entry buffer and display-group sequencer. It replaces the fixed four-digit ring capture and two-group SSD alternation in the current top level.
- Accepts debounced single-cycle key pulses with a 4-bit key code.
- Stores up to NUM_DIGITS digits in entry order.
- Supports clear, backspace and enter keys.
- Sequences NUM_GROUPS display groups for the SSD chip-select multiplexing.
- Feeds the per-digit disp_ctrl instances and the downstream lock comparator.

---
 rtl/keypad_code_buffer_if.sv | 36 +++
 rtl/keypad_code_buffer.sv | 112 +++++++++++
 tb/tb_keypad_code_buffer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_code_buffer_if.sv
// Keypad buffer bus: key/clear/mux-tick inputs plus buffer, commit and display-group outputs.
// The master drives keys and ticks; the slave (buffer) owns every registered output.
interface keypad_code_buffer_if #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_GROUPS = 2
);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int G  = NUM_DIGITS / NUM_GROUPS;

  logic                    clear;
  logic                    key_valid;
  logic [3:0]              key_code;
  logic                    mux_tick;
  logic [NUM_DIGITS*4-1:0] digit_bus;
  logic [CW-1:0]           entry_count;
  logic                    full;
  logic                    entered;
  logic [NUM_DIGITS*4-1:0] entered_code;
  logic                    err;
  logic [GW-1:0]           grp_sel;
  logic [G*4-1:0]          disp_digits;
  logic [G-1:0]            disp_blank;

  modport master (
    output clear, key_valid, key_code, mux_tick,
    input  digit_bus, entry_count, full, entered, entered_code, err,
           grp_sel, disp_digits, disp_blank
  );

  modport slave (
    input  clear, key_valid, key_code, mux_tick,
    output digit_bus, entry_count, full, entered, entered_code, err,
           grp_sel, disp_digits, disp_blank
  );
endinterface

// File: rtl/keypad_code_buffer.sv
// Keypad digit buffer with clear/backspace/enter and SSD group sequencing; 1-cycle key latency.
// No backpressure: every key pulse is consumed (applied, or rejected with an err pulse).
module keypad_code_buffer #(
  parameter int         NUM_DIGITS = 4,
  parameter int         NUM_GROUPS = 2,
  parameter bit         FULL_MODE  = 1'b0,
  parameter logic [3:0] ENTER_KEY  = 4'hF,
  parameter logic [3:0] CLEAR_KEY  = 4'hE,
  parameter logic [3:0] BACK_KEY   = 4'hD
) (
  input logic                  clk,
  input logic                  rst,
  keypad_code_buffer_if.slave  bus
);
  localparam int DW = NUM_DIGITS * 4;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int G  = NUM_DIGITS / NUM_GROUPS;
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_DIGITS);
  localparam logic [GW-1:0] LAST_GRP = GW'(NUM_GROUPS - 1);

  logic [DW-1:0]  digits_q, digits_d;
  logic [DW-1:0]  code_q, code_d;
  logic [CW-1:0]  count_q, count_d;
  logic           entered_q, entered_d;
  logic           err_q, err_d;
  logic           full_q;
  logic [GW-1:0]  grp_q;
  logic [G*4-1:0] disp_digits_c;
  logic [G-1:0]   disp_blank_c;

  always_comb begin
    digits_d  = digits_q;
    count_d   = count_q;
    code_d    = code_q;
    entered_d = 1'b0;
    err_d     = 1'b0;
    if (bus.clear) begin
      digits_d = '0;
      count_d  = '0;
    end else if (bus.key_valid) begin
      if (bus.key_code == ENTER_KEY) begin
        if (count_q == FULL_CNT) begin
          entered_d = 1'b1;
          code_d    = digits_q;
          digits_d  = '0;
          count_d   = '0;
        end else begin
          err_d = 1'b1;
        end
      end else if (bus.key_code == CLEAR_KEY) begin
        digits_d = '0;
        count_d  = '0;
      end else if (bus.key_code == BACK_KEY) begin
        if (count_q != '0) begin
          digits_d[4*(int'(count_q)-1) +: 4] = 4'h0;
          count_d = count_q - CW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (count_q != FULL_CNT) begin
        digits_d[4*int'(count_q) +: 4] = bus.key_code;
        count_d = count_q + CW'(1);
      end else if (FULL_MODE) begin
        err_d = 1'b1;
      end else begin
        // Wrap mode: a digit on a full buffer starts a fresh entry.
        digits_d      = '0;
        digits_d[3:0] = bus.key_code;
        count_d       = CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      digits_q  <= '0;
      code_q    <= '0;
      count_q   <= '0;
      entered_q <= 1'b0;
      err_q     <= 1'b0;
      full_q    <= 1'b0;
      grp_q     <= '0;
    end else begin
      digits_q  <= digits_d;
      code_q    <= code_d;
      count_q   <= count_d;
      entered_q <= entered_d;
      err_q     <= err_d;
      full_q    <= (count_d == FULL_CNT);
      if (bus.mux_tick) grp_q <= (grp_q == LAST_GRP) ? '0 : grp_q + GW'(1);
    end
  end

  // Display window: the G slots of the active group, blanked above the fill level.
  always_comb begin
    disp_digits_c = digits_q[int'(grp_q)*G*4 +: G*4];
    disp_blank_c  = '0;
    for (int j = 0; j < G; j++)
      disp_blank_c[j] = (int'(grp_q)*G + j) >= int'(count_q);
  end

  assign bus.digit_bus    = digits_q;
  assign bus.entry_count  = count_q;
  assign bus.full         = full_q;
  assign bus.entered      = entered_q;
  assign bus.entered_code = code_q;
  assign bus.err          = err_q;
  assign bus.grp_sel      = grp_q;
  assign bus.disp_digits  = disp_digits_c;
  assign bus.disp_blank   = disp_blank_c;
endmodule

// File: tb/tb_keypad_code_buffer.sv
// Bench: wrap/lock 4-digit buffers driven by a shared vector table, plus a 6-digit/3-group display instance.
module tb_keypad_code_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  keypad_code_buffer_if #(.NUM_DIGITS(4), .NUM_GROUPS(2)) i0 ();
  keypad_code_buffer_if #(.NUM_DIGITS(4), .NUM_GROUPS(2)) i1 ();
  keypad_code_buffer_if #(.NUM_DIGITS(6), .NUM_GROUPS(3)) i2 ();

  keypad_code_buffer #(.NUM_DIGITS(4), .NUM_GROUPS(2), .FULL_MODE(1'b0)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
  keypad_code_buffer #(.NUM_DIGITS(4), .NUM_GROUPS(2), .FULL_MODE(1'b1)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  keypad_code_buffer #(.NUM_DIGITS(6), .NUM_GROUPS(3), .FULL_MODE(1'b0)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));

  typedef struct {
    int          id;
    logic        clr;
    logic        kv;
    logic [3:0]  kc;
    logic [2:0]  c0;
    logic [15:0] b0;
    logic        e0;
    logic        n0;
    logic [15:0] k0;
    logic [2:0]  c1;
    logic [15:0] b1;
    logic        e1;
    logic        n1;
    logic [15:0] k1;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic clr, input logic kv, input logic [3:0] kc,
                              input logic [2:0] c0, input logic [15:0] b0, input logic e0,
                              input logic n0, input logic [15:0] k0,
                              input logic [2:0] c1, input logic [15:0] b1, input logic e1,
                              input logic n1, input logic [15:0] k1);
    vec_t v;
    v.id = vecs.size(); v.clr = clr; v.kv = kv; v.kc = kc;
    v.c0 = c0; v.b0 = b0; v.e0 = e0; v.n0 = n0; v.k0 = k0;
    v.c1 = c1; v.b1 = b1; v.e1 = e1; v.n1 = n1; v.k1 = k1;
    vecs.push_back(v);
  endfunction

  task automatic check_row(input vec_t v);
    chk($sformatf("r%0d_cnt0", v.id),  32'(i0.entry_count), 32'(v.c0));
    chk($sformatf("r%0d_bus0", v.id),  32'(i0.digit_bus), 32'(v.b0));
    chk($sformatf("r%0d_full0", v.id), 32'(i0.full), 32'(v.c0 == 3'd4));
    chk($sformatf("r%0d_err0", v.id),  32'(i0.err), 32'(v.e0));
    chk($sformatf("r%0d_ent0", v.id),  32'(i0.entered), 32'(v.n0));
    chk($sformatf("r%0d_code0", v.id), 32'(i0.entered_code), 32'(v.k0));
    chk($sformatf("r%0d_cnt1", v.id),  32'(i1.entry_count), 32'(v.c1));
    chk($sformatf("r%0d_bus1", v.id),  32'(i1.digit_bus), 32'(v.b1));
    chk($sformatf("r%0d_full1", v.id), 32'(i1.full), 32'(v.c1 == 3'd4));
    chk($sformatf("r%0d_err1", v.id),  32'(i1.err), 32'(v.e1));
    chk($sformatf("r%0d_ent1", v.id),  32'(i1.entered), 32'(v.n1));
    chk($sformatf("r%0d_code1", v.id), 32'(i1.entered_code), 32'(v.k1));
  endtask

  task automatic key0(input logic [3:0] c);
    i0.key_valid = 1'b1; i0.key_code = c;
    @(negedge clk);
    i0.key_valid = 1'b0;
  endtask

  task automatic key2(input logic [3:0] c);
    i2.key_valid = 1'b1; i2.key_code = c;
    @(negedge clk);
    i2.key_valid = 1'b0;
  endtask

  task automatic tick0();
    i0.mux_tick = 1'b1;
    @(negedge clk);
    i0.mux_tick = 1'b0;
  endtask

  task automatic tick2();
    i2.mux_tick = 1'b1;
    @(negedge clk);
    i2.mux_tick = 1'b0;
  endtask

  initial begin
    i0.clear = 0; i0.key_valid = 0; i0.key_code = 0; i0.mux_tick = 0;
    i1.clear = 0; i1.key_valid = 0; i1.key_code = 0; i1.mux_tick = 0;
    i2.clear = 0; i2.key_valid = 0; i2.key_code = 0; i2.mux_tick = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    chk("rst_cnt0",   32'(i0.entry_count), 0);
    chk("rst_bus0",   32'(i0.digit_bus), 0);
    chk("rst_full0",  32'(i0.full), 0);
    chk("rst_err0",   32'(i0.err), 0);
    chk("rst_ent0",   32'(i0.entered), 0);
    chk("rst_code0",  32'(i0.entered_code), 0);
    chk("rst_grp0",   32'(i0.grp_sel), 0);
    chk("rst_blank0", 32'(i0.disp_blank), 32'h3);
    chk("rst_bus2",   32'(i2.digit_bus), 0);
    chk("rst_blank2", 32'(i2.disp_blank), 32'h3);
    chk("rst_disp2",  32'(i2.disp_digits), 0);

    //   clr kv  kc     c0  b0     e0 n0 k0         c1  b1     e1 n1 k1
    add(0, 1, 4'h1, 1, 16'h0001, 0, 0, 16'h0000, 1, 16'h0001, 0, 0, 16'h0000);
    add(0, 1, 4'h2, 2, 16'h0021, 0, 0, 16'h0000, 2, 16'h0021, 0, 0, 16'h0000);
    add(0, 1, 4'h3, 3, 16'h0321, 0, 0, 16'h0000, 3, 16'h0321, 0, 0, 16'h0000);
    add(0, 1, 4'h4, 4, 16'h4321, 0, 0, 16'h0000, 4, 16'h4321, 0, 0, 16'h0000);
    add(0, 1, 4'h9, 1, 16'h0009, 0, 0, 16'h0000, 4, 16'h4321, 1, 0, 16'h0000);
    add(0, 1, 4'hF, 1, 16'h0009, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h4321);
    add(0, 1, 4'hD, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h4321);
    add(0, 1, 4'hD, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h4321);
    add(0, 1, 4'h5, 1, 16'h0005, 0, 0, 16'h0000, 1, 16'h0005, 0, 0, 16'h4321);
    add(0, 1, 4'hF, 1, 16'h0005, 1, 0, 16'h0000, 1, 16'h0005, 1, 0, 16'h4321);
    add(0, 1, 4'hD, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h4321);
    add(0, 1, 4'hA, 1, 16'h000A, 0, 0, 16'h0000, 1, 16'h000A, 0, 0, 16'h4321);
    add(0, 1, 4'hB, 2, 16'h00BA, 0, 0, 16'h0000, 2, 16'h00BA, 0, 0, 16'h4321);
    add(0, 1, 4'hC, 3, 16'h0CBA, 0, 0, 16'h0000, 3, 16'h0CBA, 0, 0, 16'h4321);
    add(0, 1, 4'h0, 4, 16'h0CBA, 0, 0, 16'h0000, 4, 16'h0CBA, 0, 0, 16'h4321);
    add(0, 1, 4'hF, 0, 16'h0000, 0, 1, 16'h0CBA, 0, 16'h0000, 0, 1, 16'h0CBA);
    add(0, 1, 4'h1, 1, 16'h0001, 0, 0, 16'h0CBA, 1, 16'h0001, 0, 0, 16'h0CBA);
    add(0, 1, 4'h2, 2, 16'h0021, 0, 0, 16'h0CBA, 2, 16'h0021, 0, 0, 16'h0CBA);
    add(0, 1, 4'h3, 3, 16'h0321, 0, 0, 16'h0CBA, 3, 16'h0321, 0, 0, 16'h0CBA);
    add(0, 1, 4'h4, 4, 16'h4321, 0, 0, 16'h0CBA, 4, 16'h4321, 0, 0, 16'h0CBA);
    add(0, 1, 4'hF, 0, 16'h0000, 0, 1, 16'h4321, 0, 16'h0000, 0, 1, 16'h4321);
    add(0, 1, 4'h7, 1, 16'h0007, 0, 0, 16'h4321, 1, 16'h0007, 0, 0, 16'h4321);
    add(0, 1, 4'hE, 0, 16'h0000, 0, 0, 16'h4321, 0, 16'h0000, 0, 0, 16'h4321);
    add(0, 1, 4'h3, 1, 16'h0003, 0, 0, 16'h4321, 1, 16'h0003, 0, 0, 16'h4321);
    add(1, 1, 4'h7, 0, 16'h0000, 0, 0, 16'h4321, 0, 16'h0000, 0, 0, 16'h4321);
    add(0, 0, 4'h7, 0, 16'h0000, 0, 0, 16'h4321, 0, 16'h0000, 0, 0, 16'h4321);
    add(0, 1, 4'h1, 1, 16'h0001, 0, 0, 16'h4321, 1, 16'h0001, 0, 0, 16'h4321);

    for (int i = 0; i < vecs.size(); i++) begin
      i0.clear = vecs[i].clr; i0.key_valid = vecs[i].kv; i0.key_code = vecs[i].kc;
      i1.clear = vecs[i].clr; i1.key_valid = vecs[i].kv; i1.key_code = vecs[i].kc;
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      if (exp_q.size() > 0) check_row(exp_q.pop_front());
    end
    i0.clear = 0; i0.key_valid = 0;
    i1.clear = 0; i1.key_valid = 0;

    // Display groups on the 4-digit buffer: clear, fill, then walk both groups.
    i0.clear = 1'b1;
    @(negedge clk);
    i0.clear = 1'b0;
    chk("clr_cnt0", 32'(i0.entry_count), 0);
    key0(4'h1); key0(4'h2); key0(4'h3); key0(4'h4);
    chk("g0_grp",   32'(i0.grp_sel), 0);
    chk("g0_disp",  32'(i0.disp_digits), 32'h21);
    chk("g0_blank", 32'(i0.disp_blank), 0);
    tick0();
    chk("g1_grp",   32'(i0.grp_sel), 1);
    chk("g1_disp",  32'(i0.disp_digits), 32'h43);
    chk("g1_blank", 32'(i0.disp_blank), 0);
    tick0();
    chk("g0_wrap",  32'(i0.grp_sel), 0);

    // Six digits over three groups.
    key2(4'h1); key2(4'h2); key2(4'h3);
    chk("u2_cnt",   32'(i2.entry_count), 3);
    chk("u2_bus",   32'(i2.digit_bus), 32'h000321);
    tick2();
    chk("u2_grp1",   32'(i2.grp_sel), 1);
    chk("u2_disp1",  32'(i2.disp_digits), 32'h03);
    chk("u2_blank1", 32'(i2.disp_blank), 32'h2);
    tick2();
    chk("u2_grp2",   32'(i2.grp_sel), 2);
    chk("u2_disp2",  32'(i2.disp_digits), 0);
    chk("u2_blank2", 32'(i2.disp_blank), 32'h3);
    tick2();
    chk("u2_grp0",   32'(i2.grp_sel), 0);
    chk("u2_disp0",  32'(i2.disp_digits), 32'h21);
    chk("u2_blank0", 32'(i2.disp_blank), 0);
    // Key and tick in the same cycle both take effect.
    i2.key_valid = 1'b1; i2.key_code = 4'h4; i2.mux_tick = 1'b1;
    @(negedge clk);
    i2.key_valid = 1'b0; i2.mux_tick = 1'b0;
    chk("u2_sim_grp",   32'(i2.grp_sel), 1);
    chk("u2_sim_cnt",   32'(i2.entry_count), 4);
    chk("u2_sim_disp",  32'(i2.disp_digits), 32'h43);
    chk("u2_sim_blank", 32'(i2.disp_blank), 0);

    // Mid-entry reset with a key pulse that must be discarded.
    rst = 1'b0;
    i0.key_valid = 1'b1; i0.key_code = 4'h7;
    @(negedge clk);
    rst = 1'b1;
    i0.key_valid = 1'b0;
    chk("mr_cnt0",   32'(i0.entry_count), 0);
    chk("mr_bus0",   32'(i0.digit_bus), 0);
    chk("mr_full0",  32'(i0.full), 0);
    chk("mr_code0",  32'(i0.entered_code), 0);
    chk("mr_code1",  32'(i1.entered_code), 0);
    chk("mr_grp2",   32'(i2.grp_sel), 0);
    chk("mr_cnt2",   32'(i2.entry_count), 0);
    chk("mr_blank2", 32'(i2.disp_blank), 32'h3);
    @(negedge clk);
    chk("mr_hold_cnt0", 32'(i0.entry_count), 0);
    chk("mr_hold_err0", 32'(i0.err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
